// File: rtl/stripes_weight_sequencer.sv
// -----------------------------------------------------------------------------
// stripes_weight_sequencer
// Feed stage in front of the 16-lane bit-serial Stripes MAC. Accepts one vector
// (weights, activations, accumulator seed), holds the activations and seed
// steady, then issues the weight bit-columns LSB first. After the sign column it
// spends one cycle flushing the MAC's shift stage and pulses res_valid_o.
//
// Ports
//   clk_i, reset_i     clock, asynchronous active-high reset
//   in_valid_i         input vector valid
//   in_ready_o         sequencer can accept (IDLE or DONE)
//   act_in_i, w_in_i   packed signed activations / weights, lane j at [j*DW +: DW]
//   accum_seed_i       partial sum to load into the MAC accumulator
//   act_out_o          latched activations to the MAC
//   w_bit_o            current weight bit-column, one bit per lane
//   column_idx_o       bit position of the current column
//   is_msb_o           current column is the sign column
//   mac_en_o           MAC enable
//   load_accum_o       MAC load_accum
//   accum_prev_o       latched seed to the MAC
//   res_valid_o        one-cycle pulse, MAC result final this cycle
//
// States
//   IDLE  | waiting for a vector, in_ready_o high
//   ISSUE | driving one weight bit-column per cycle into the MAC
//   FLUSH | MAC enabled with zero bits to drain its shift stage
//   DONE  | result valid; a new vector may be accepted here
// -----------------------------------------------------------------------------
module stripes_weight_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int ACC_WIDTH     = DATA_WIDTH + 16,
    parameter bit SKIP_ZERO_COL = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_in_i,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in_i,
    input  logic [ACC_WIDTH-1:0]             accum_seed_i,
    output logic [VEC_LENGTH*DATA_WIDTH-1:0] act_out_o,
    output logic [VEC_LENGTH-1:0]            w_bit_o,
    output logic [2:0]                       column_idx_o,
    output logic                             is_msb_o,
    output logic                             mac_en_o,
    output logic                             load_accum_o,
    output logic [ACC_WIDTH-1:0]             accum_prev_o,
    output logic                             res_valid_o
);

    localparam int          VW      = VEC_LENGTH * DATA_WIDTH;
    localparam int          IW      = $clog2(VW);
    localparam logic [2:0]  MSB_COL = 3'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              col_q, col_d;
    logic                    first_q, first_d;
    logic [VW-1:0]           w_q, act_q;
    logic [ACC_WIDTH-1:0]    seed_q;
    logic                    ready_q, ready_d;
    logic [VEC_LENGTH-1:0]   wbit_q, wbit_d;
    logic [2:0]              idx_q, idx_d;
    logic                    msb_q, msb_d;
    logic                    en_q, en_d;
    logic                    load_q, load_d;
    logic                    res_q, res_d;
    logic                    accept;
    logic [VW-1:0]           w_src;

    function automatic logic [VEC_LENGTH-1:0] col_bits(input logic [VW-1:0] w,
                                                       input logic [2:0]    c);
        logic [VEC_LENGTH-1:0] b;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            b[j] = w[IW'(j * DATA_WIDTH + int'(c))];
        end
        return b;
    endfunction

    // Lowest column at or above start that must be issued. The sign column is
    // always a candidate so an all-zero vector still gets one MAC cycle.
    function automatic logic [2:0] next_col(input logic [VW-1:0] w,
                                            input logic [3:0]    start);
        logic [2:0] r;
        r = MSB_COL;
        for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
            if (c >= int'(start) &&
                (!SKIP_ZERO_COL || c == DATA_WIDTH - 1 || (|col_bits(w, 3'(c))))) begin
                r = 3'(c);
            end
        end
        return r;
    endfunction

    assign accept = in_valid_i & ready_q;
    // Column bits for the first ISSUE cycle come straight from the inputs,
    // since the weight registers are loaded on the same edge.
    assign w_src  = accept ? w_in_i : w_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ready_d = 1'b0;
        wbit_d  = '0;
        idx_d   = 3'd0;
        msb_d   = 1'b0;
        en_d    = 1'b0;
        res_d   = 1'b0;
        first_d = accept;
        // first_q marks the first ISSUE cycle; the seed is loaded one cycle later
        // so it lines up with the first shifted partial sum inside the MAC.
        load_d  = (state_q == ISSUE) && first_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    col_d   = next_col(w_in_i, 4'd0);
                end
            end
            ISSUE: begin
                if (col_q == MSB_COL) begin
                    state_d = FLUSH;
                end else begin
                    col_d = next_col(w_q, {1'b0, col_q} + 4'd1);
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
                if (accept) begin
                    state_d = ISSUE;
                    col_d   = next_col(w_in_i, 4'd0);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            IDLE: ready_d = 1'b1;
            ISSUE: begin
                en_d   = 1'b1;
                wbit_d = col_bits(w_src, col_d);
                idx_d  = col_d;
                msb_d  = (col_d == MSB_COL);
            end
            FLUSH: en_d = 1'b1;
            DONE: begin
                res_d   = 1'b1;
                ready_d = 1'b1;
            end
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            col_q   <= 3'd0;
            first_q <= 1'b0;
            w_q     <= '0;
            act_q   <= '0;
            seed_q  <= '0;
            ready_q <= 1'b1;
            wbit_q  <= '0;
            idx_q   <= 3'd0;
            msb_q   <= 1'b0;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            first_q <= first_d;
            if (accept) begin
                w_q    <= w_in_i;
                act_q  <= act_in_i;
                seed_q <= accum_seed_i;
            end
            ready_q <= ready_d;
            wbit_q  <= wbit_d;
            idx_q   <= idx_d;
            msb_q   <= msb_d;
            en_q    <= en_d;
            load_q  <= load_d;
            res_q   <= res_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign act_out_o    = act_q;
    assign w_bit_o      = wbit_q;
    assign column_idx_o = idx_q;
    assign is_msb_o     = msb_q;
    assign mac_en_o     = en_q;
    assign load_accum_o = load_q;
    assign accum_prev_o = seed_q;
    assign res_valid_o  = res_q;

endmodule
